// File: rtl/pic_host_sequencer_pkg.sv
// Shared types and constants for the PIC host sequencer: FSM states, write
// kinds, ICW1 flag positions and the ICW-step helper.
package pic_host_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_NEXT,
    S_INTA1, S_GAP, S_INTA2, S_CAPTURE
`ifdef PIC_HOST_AUTO_EOI_EN
    , S_EOI
`endif
  } state_t;

  typedef enum logic [1:0] {OP_ICW, OP_OCW, OP_EOI} op_t;

  localparam int         ICW1_IC4_BIT  = 0;
  localparam int         ICW1_SNGL_BIT = 1;
  localparam int         ICW1_ID_BIT   = 4;
  localparam logic [7:0] OCW2_NS_EOI   = 8'h20;

  typedef struct packed {
    logic       more;
    logic [1:0] idx;
  } icw_step_t;

  // Which ICW follows ICW<idx+1>; ICW3 exists only in cascade mode, ICW4 only with IC4.
  function automatic icw_step_t icw_next(input logic [1:0] idx, input logic [7:0] icw1);
    icw_step_t s;
    s.more = 1'b0;
    s.idx  = 2'd0;
    case (idx)
      2'd0: begin s.more = 1'b1; s.idx = 2'd1; end
      2'd1: begin
        if (!icw1[ICW1_SNGL_BIT])    begin s.more = 1'b1; s.idx = 2'd2; end
        else if (icw1[ICW1_IC4_BIT]) begin s.more = 1'b1; s.idx = 2'd3; end
      end
      2'd2: if (icw1[ICW1_IC4_BIT]) begin s.more = 1'b1; s.idx = 2'd3; end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pic_host_sequencer_if.sv
// CPU-side pin bundle of the 8259-style PIC: write strobe, INTA, address and data.
interface pic_host_sequencer_if;
  logic       intr;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;
  logic       a0;
  logic       wr_n;
  logic       inta_n;

  modport master (input intr, d_in, output d_out, d_oe, a0, wr_n, inta_n);
  modport slave  (output intr, d_in, input d_out, d_oe, a0, wr_n, inta_n);
endinterface

// File: rtl/pic_host_sequencer_timer.sv
// Loadable down-counter timing the wr_n strobe, both INTA pulses and the INTA gap.
module pic_strobe_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (load)                 cnt <= load_val;
    else if (count && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/pic_host_sequencer.sv
// Bus master for an 8259-style PIC: ICW init sequence, OCW writes, two-pulse INTA.
// Define PIC_HOST_AUTO_EOI_EN to follow every INTA with a non-specific EOI write.
module pic_host_sequencer
  import pic_host_pkg::*;
#(
  parameter int WR_PULSE   = 2,
  parameter int INTA_PULSE = 2,
  parameter int INTA_GAP   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        init_start,
  input  logic [7:0]                  icw1,
  input  logic [7:0]                  icw2,
  input  logic [7:0]                  icw3,
  input  logic [7:0]                  icw4,
  input  logic                        ocw_req,
  input  logic                        ocw_a0,
  input  logic [7:0]                  ocw_data,
  output logic                        ocw_ack,
  pic_host_sequencer_if.master        bus,
  output logic [7:0]                  vector,
  output logic                        vector_valid,
  output logic                        init_done,
  output logic                        busy
);
  localparam logic [7:0] WR_LD       = 8'(WR_PULSE - 1);
  localparam logic [7:0] INTA_LD     = 8'(INTA_PULSE - 1);
  localparam logic [7:0] GAP_LD      = 8'(INTA_GAP - 1);
  localparam logic [7:0] ICW1_ID_SET = 8'(1 << ICW1_ID_BIT);

  state_t          state;
  op_t             op;
  logic [1:0]      icw_idx;
  logic [3:0][7:0] icw_r;
  logic            wr_n, inta_n, d_oe, a0;
  logic [7:0]      d_out;
  logic            tmr_load, tmr_count, tmr_done;
  logic [7:0]      tmr_val;
  icw_step_t       step;

  assign step = icw_next(icw_idx, icw_r[0]);

  // The timer is loaded in the cycle before a timed state, so its value is
  // ready on the first cycle of that state.
  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      S_IDLE:  if (!init_start && init_done && bus.intr) begin tmr_load = 1'b1; tmr_val = INTA_LD; end
      S_SETUP: begin tmr_load = 1'b1; tmr_val = WR_LD; end
      S_INTA1: if (tmr_done) begin tmr_load = 1'b1; tmr_val = GAP_LD; end
      S_GAP:   if (tmr_done) begin tmr_load = 1'b1; tmr_val = INTA_LD; end
      default: ;
    endcase
  end

  assign tmr_count = (state == S_STROBE) || (state == S_INTA1) ||
                     (state == S_GAP)    || (state == S_INTA2);

  pic_strobe_timer #(.W(8)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op           <= OP_ICW;
      icw_idx      <= 2'd0;
      icw_r        <= '0;
      wr_n         <= 1'b1;
      inta_n       <= 1'b1;
      d_oe         <= 1'b0;
      a0           <= 1'b0;
      d_out        <= 8'h00;
      vector       <= 8'h00;
      vector_valid <= 1'b0;
      ocw_ack      <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      ocw_ack      <= 1'b0;
      vector_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (init_start) begin
            icw_r     <= {icw4, icw3, icw2, icw1};
            init_done <= 1'b0;
            op        <= OP_ICW;
            icw_idx   <= 2'd0;
            a0        <= 1'b0;
            d_out     <= icw1 | ICW1_ID_SET;
            d_oe      <= 1'b1;
            state     <= S_SETUP;
          end else if (init_done && bus.intr) begin
            inta_n <= 1'b0;
            state  <= S_INTA1;
          end else if (init_done && ocw_req) begin
            op    <= OP_OCW;
            a0    <= ocw_a0;
            d_out <= ocw_data;
            d_oe  <= 1'b1;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          wr_n  <= 1'b0;
          state <= S_STROBE;
        end
        S_STROBE: if (tmr_done) begin
          wr_n  <= 1'b1;
          state <= S_HOLD;
        end
        S_HOLD: begin
          d_oe  <= 1'b0;
          state <= S_NEXT;
          if (op == OP_ICW && !step.more) init_done <= 1'b1;
          if (op == OP_OCW)               ocw_ack   <= 1'b1;
        end
        S_NEXT: begin
          if (op == OP_ICW && step.more) begin
            icw_idx <= step.idx;
            a0      <= 1'b1;
            d_out   <= icw_r[step.idx];
            d_oe    <= 1'b1;
            state   <= S_SETUP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_INTA1: if (tmr_done) begin
          inta_n <= 1'b1;
          state  <= S_GAP;
        end
        S_GAP: if (tmr_done) begin
          inta_n <= 1'b0;
          state  <= S_INTA2;
        end
        S_INTA2: if (tmr_done) begin
          vector       <= bus.d_in;
          vector_valid <= 1'b1;
          inta_n       <= 1'b1;
          state        <= S_CAPTURE;
        end
`ifdef PIC_HOST_AUTO_EOI_EN
        S_CAPTURE: state <= S_EOI;
        S_EOI: begin
          op    <= OP_EOI;
          a0    <= 1'b0;
          d_out <= OCW2_NS_EOI;
          d_oe  <= 1'b1;
          state <= S_SETUP;
        end
`else
        S_CAPTURE: state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.wr_n   = wr_n;
  assign bus.inta_n = inta_n;
  assign bus.d_oe   = d_oe;
  assign bus.a0     = a0;
  assign bus.d_out  = d_out;
  assign busy       = (state != S_IDLE);
endmodule

// File: tb/tb_pic_host_sequencer.sv
// Scoreboard bench for pic_host_sequencer: a PIC pin model plus a monitor that
// checks bus writes, INTA pulse timing and captured vectors against a queue.
module tb_pic_host_sequencer;
  localparam int WR_PULSE   = 2;
  localparam int INTA_PULSE = 2;
  localparam int INTA_GAP   = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init_start, ocw_req, ocw_a0, ocw_ack;
  logic [7:0] icw1, icw2, icw3, icw4, ocw_data, vector;
  logic       vector_valid, init_done, busy;
  logic       int_line;
  logic [7:0] pic_din, pic_vec;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_wr_rise = 0;

  typedef struct {
    bit         is_vec;
    logic       a0;
    logic [7:0] data;
  } ev_t;
  ev_t exp_q[$];

  pic_host_sequencer_if bus ();
  assign bus.intr = int_line;
  assign bus.d_in = pic_din;

  pic_host_sequencer #(.WR_PULSE(WR_PULSE), .INTA_PULSE(INTA_PULSE), .INTA_GAP(INTA_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .ocw_req(ocw_req), .ocw_a0(ocw_a0), .ocw_data(ocw_data), .ocw_ack(ocw_ack),
    .bus(bus), .vector(vector), .vector_valid(vector_valid),
    .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_vec, input logic a0v, input logic [7:0] data);
    ev_t e;
    e.is_vec = is_vec; e.a0 = a0v; e.data = data;
    exp_q.push_back(e);
  endtask

  // PIC model: drives the vector only during the second INTA pulse, noise otherwise.
  int  pic_pulses = 0;
  bit  pic_in2 = 0;
  bit  pic_prev_inta = 1;
  always @(negedge clk) begin
    if (!rst_n) begin
      pic_pulses = 0; pic_in2 = 0; pic_prev_inta = 1;
    end else begin
      if (pic_prev_inta && !bus.inta_n) begin
        if (pic_pulses == 0) pic_pulses = 1;
        else begin pic_pulses = 0; pic_in2 = 1; end
      end else if (!pic_prev_inta && bus.inta_n) begin
        pic_in2 = 0;
      end
      pic_prev_inta = bus.inta_n;
    end
    pic_din = pic_in2 ? pic_vec : 8'($urandom);
  end

  // Monitor: pops the scoreboard on each write strobe and each vector_valid.
  bit prev_wr = 1, prev_inta = 1, prev_vv = 0, hold_seen = 0;
  int wr_low = 0, inta_low = 0, gap = 0, inta_phase = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr = 1; prev_inta = 1; prev_vv = 0; hold_seen = 0;
      wr_low = 0; inta_low = 0; gap = 0; inta_phase = 0;
    end else begin
      if (prev_wr && !bus.wr_n) begin
        ev_t e;
        wr_low = 1;
        check("wr_doe", bus.d_oe, 1);
        check("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_kind", e.is_vec, 0);
          check("wr_a0", bus.a0, e.a0);
          check("wr_data", bus.d_out, e.data);
        end
      end else if (!bus.wr_n) begin
        wr_low++;
      end
      if (!prev_wr && bus.wr_n) begin
        check("wr_pulse_len", wr_low, WR_PULSE);
        check("hold_doe", bus.d_oe, 1);
        hold_seen = 1;
        last_wr_rise = cyc;
      end else if (hold_seen) begin
        check("after_hold_doe", bus.d_oe, 0);
        hold_seen = 0;
      end

      if (prev_inta && !bus.inta_n) begin
        if (inta_phase == 2) begin
          check("inta_gap_len", gap, INTA_GAP);
          inta_phase = 3;
        end else begin
          check("inta_first_phase", inta_phase, 0);
          inta_phase = 1;
        end
        inta_low = 1;
      end else if (!bus.inta_n) begin
        inta_low++;
      end else if (!prev_inta && bus.inta_n) begin
        check("inta_pulse_len", inta_low, INTA_PULSE);
        if (inta_phase == 1) begin inta_phase = 2; gap = 1; end
        else inta_phase = 0;
      end else if (inta_phase == 2) begin
        gap++;
      end
      if (!bus.inta_n) check("inta_bus_quiet", {bus.wr_n, bus.d_oe}, 2'b10);

      if (vector_valid) begin
        ev_t e;
        check("vv_single", prev_vv, 0);
        check("vv_after_inta", inta_phase, 0);
        check("vec_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("vec_kind", e.is_vec, 1);
          check("vector", vector, e.data);
        end
      end
      prev_wr = bus.wr_n; prev_inta = bus.inta_n; prev_vv = vector_valid;
    end
  end

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      if (!busy && exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(name, k < 200, 1);
  endtask

  task automatic run_init(input logic [7:0] i1, i2, i3, i4);
    int k;
    push(0, 1'b0, i1 | 8'h10);
    push(0, 1'b1, i2);
    if (!i1[1]) push(0, 1'b1, i3);
    if (i1[0])  push(0, 1'b1, i4);
    icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4;
    init_start = 1;
    @(negedge clk);
    init_start = 0;
    icw1 = 8'($urandom); icw2 = 8'($urandom); icw3 = 8'($urandom); icw4 = 8'($urandom);
    check("init_done_cleared", init_done, 0);
    for (k = 0; k < 200; k++) begin
      if (init_done) break;
      @(negedge clk);
    end
    check("init_done_timeout", k < 200, 1);
    check("init_done_latency", cyc - last_wr_rise, 1);
    check("init_writes_left", exp_q.size(), 0);
    wait_idle("init_idle");
  endtask

  task automatic wait_inta_drop_intr();
    int k;
    for (k = 0; k < 50; k++) begin
      if (!bus.inta_n) break;
      @(negedge clk);
    end
    check("inta_start_timeout", k < 50, 1);
    int_line = 0;
  endtask

  task automatic push_vec(input logic [7:0] v);
    pic_vec = v;
    push(1, 1'b0, v);
`ifdef PIC_HOST_AUTO_EOI_EN
    push(0, 1'b0, 8'h20);
`endif
  endtask

  task automatic wait_ack();
    int k;
    for (k = 0; k < 200; k++) begin
      if (ocw_ack) break;
      @(negedge clk);
    end
    check("ocw_ack_timeout", k < 200, 1);
    ocw_req = 0;
  endtask

  task automatic run_int(input logic [7:0] v);
    push_vec(v);
    int_line = 1;
    wait_inta_drop_intr();
    wait_idle("int_idle");
    @(negedge clk);
  endtask

  task automatic run_ocw(input logic a, input logic [7:0] d);
    push(0, a, d);
    ocw_a0 = a; ocw_data = d; ocw_req = 1;
    wait_ack();
    wait_idle("ocw_idle");
    @(negedge clk);
  endtask

  task automatic run_int_ocw(input logic [7:0] v, input logic a, input logic [7:0] d);
    push_vec(v);
    push(0, a, d);
    ocw_a0 = a; ocw_data = d;
    int_line = 1; ocw_req = 1;
    wait_inta_drop_intr();
    wait_ack();
    wait_idle("int_ocw_idle");
    @(negedge clk);
  endtask

  task automatic check_ignored(input string name);
    int_line = 1; ocw_req = 1; ocw_a0 = 1; ocw_data = 8'hFB;
    repeat (10) begin
      @(negedge clk);
      if (busy || !bus.inta_n || ocw_ack) break;
    end
    check({name, "_busy"}, busy, 0);
    check({name, "_inta"}, bus.inta_n, 1);
    check({name, "_ack"}, ocw_ack, 0);
    int_line = 0; ocw_req = 0;
    @(negedge clk);
  endtask

  initial begin
    int k;
    rst_n = 0; init_start = 0; ocw_req = 0; ocw_a0 = 0; ocw_data = 0;
    icw1 = 0; icw2 = 0; icw3 = 0; icw4 = 0; int_line = 0; pic_vec = 0;
    repeat (3) @(negedge clk);
    check("rst_wr_n", bus.wr_n, 1);
    check("rst_inta_n", bus.inta_n, 1);
    check("rst_d_oe", bus.d_oe, 0);
    check("rst_a0", bus.a0, 0);
    check("rst_d_out", bus.d_out, 0);
    check("rst_vector", vector, 0);
    check("rst_vv", vector_valid, 0);
    check("rst_ack", ocw_ack, 0);
    check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 0);
    rst_n = 1;
    @(negedge clk);

    check_ignored("pre_init");
    run_init(8'h11, 8'h40, 8'h00, 8'h01);
    run_init(8'h13, 8'h40, 8'h00, 8'h01);
    run_int(8'h45);
    run_int(8'h42);
    run_int_ocw(8'h47, 1'b1, 8'hFB);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: run_int(8'($urandom));
        1: run_ocw(1'($urandom), 8'($urandom));
        2: run_int_ocw(8'($urandom), 1'($urandom), 8'($urandom));
        default: run_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      endcase
    end

    // Reset in the middle of the first ICW strobe abandons the sequence.
    push(0, 1'b0, 8'h11); push(0, 1'b1, 8'h40); push(0, 1'b1, 8'h00); push(0, 1'b1, 8'h01);
    icw1 = 8'h11; icw2 = 8'h40; icw3 = 8'h00; icw4 = 8'h01;
    init_start = 1;
    @(negedge clk);
    init_start = 0;
    for (k = 0; k < 20; k++) begin
      if (!bus.wr_n) break;
      @(negedge clk);
    end
    check("strobe_seen", k < 20, 1);
    rst_n = 0;
    #1;
    check("midrst_wr_n", bus.wr_n, 1);
    check("midrst_d_oe", bus.d_oe, 0);
    check("midrst_init_done", init_done, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_ignored("post_rst");
    run_init(8'h11, 8'h40, 8'h00, 8'h01);
    run_int(8'h5A);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
